// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues fetch addresses to a 1-cycle-latency
// instruction memory and hands results to decode through a 2-entry buffer.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    entry_t                head_q, head_d;
    entry_t                tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    logic       pop;
    logic       push;
    logic       redir;
    logic       issue;
    logic [2:0] occ;
    entry_t     resp;

    assign out_valid       = (count_q != 2'd0);
    assign out_instruction = head_q.instr;
    assign out_pc          = head_q.pc;
    assign busy            = (state_q != IDLE);

    assign pop   = out_valid & out_ready;
    assign redir = redirect_valid & (state_q != IDLE);

    // Slots committed after this cycle: what is held plus what is landing,
    // minus what decode takes now. Keeps the buffer from ever overflowing.
    assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == FETCH) & ~stop & ~redir & (occ < 3'd2);

    // A redirect squashes the read landing this cycle.
    assign push = inflight_q & ~redir;
    assign resp = '{pc: inflight_pc_q, instr: mem_instruction};

    assign mem_req     = issue;
    assign mem_address = issue ? pc_q : addr_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end
            FETCH: begin
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            addr_d        = pc_q;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 1'b1;
        end
        if (redir) pc_d = redirect_addr;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = resp;
                else                 tail_d = resp;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = resp;
                end else begin
                    head_d = resp;
                end
            end
            default: ;
        endcase

        if (redir) count_d = 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, hand-written corner sequences and
// random traffic compared against a queue-based model of the fetch rules.
module tb_fetch_sequencer;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_req;
    logic [DW-1:0] mem_instruction;
    logic          out_valid;
    logic [DW-1:0] out_instruction;
    logic [AW-1:0] out_pc;
    logic          busy;

    fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .mem_address(mem_address), .mem_req(mem_req),
        .mem_instruction(mem_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    logic [DW-1:0] imem [8];
    always @(posedge clk) if (mem_req) mem_instruction <= imem[mem_address];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } ent_t;

    // Model: issue-order queue of buffered entries plus one in-flight read.
    ent_t mq[$];
    int   mmode;     // 0 idle, 1 fetching, 2 draining
    int   mpc;
    bit   minf;
    int   minf_pc;
    int   maddr;
    int   got[$];    // pcs actually handed to decode

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mmode = 0; mpc = 0; minf = 0; minf_pc = 0; maddr = 0;
        got.delete();
    endtask

    task automatic drv(input bit s, input bit p, input bit rv, input int ra, input bit rdy);
        start = s; stop = p; redirect_valid = rv; redirect_addr = ra[AW-1:0]; out_ready = rdy;
    endtask

    // Called at the negedge: compare, advance the model, move to posedge+1.
    task automatic tick();
        bit   ev, pop, req, rv, done;
        int   occ;
        ent_t e;
        ev   = (mq.size() > 0);
        pop  = ev && out_ready;
        occ  = mq.size() + int'(minf) - int'(pop);
        rv   = redirect_valid && (mmode != 0);
        req  = (mmode == 1) && !rv && !stop && (occ < 2);
        done = (mmode == 2) && (mq.size() == 0) && !minf;
        chk("mem_req", mem_req, req);
        chk("mem_address", mem_address, req ? mpc : maddr);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, mmode != 0);
        if (ev) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instruction", out_instruction, mq[0].ins);
        end
        if (out_valid && out_ready) got.push_back(int'(out_pc));
        if (pop) void'(mq.pop_front());
        if (minf) begin
            e.pc = minf_pc[AW-1:0]; e.ins = imem[minf_pc]; mq.push_back(e);
        end
        if (rv) mq.delete();
        minf = req; minf_pc = mpc;
        if (req) begin maddr = mpc; mpc = (mpc + 1) % 8; end
        if (rv) mpc = int'(redirect_addr);
        case (mmode)
            0: if (start) begin mmode = 1; mpc = 0; end
            1: if (stop) mmode = 2;
            2: if (done) mmode = 0;
            default: mmode = 0;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        tick();
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic do_reset();
        drv(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_out_pc", out_pc, '0);
        @(negedge clk); #2 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit st; bit rdy; bit req; int addr; bit vld; int pc; bit bsy;
    } vec_t;

    initial begin
        vec_t tbl[7];
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 1, 1, 0, 0, 1};
        tbl[3] = '{0, 1, 1, 2, 1, 0, 1};
        tbl[4] = '{0, 1, 1, 3, 1, 1, 1};
        tbl[5] = '{0, 1, 1, 4, 1, 2, 1};
        tbl[6] = '{0, 1, 1, 5, 1, 3, 1};

        for (int i = 0; i < 8; i++) imem[i] = 32'h1000_0000 + i;
        model_reset();

        #2;
        chk("init_mem_req", mem_req, 1'b0);
        chk("init_mem_address", mem_address, '0);
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_out_instruction", out_instruction, '0);
        chk("init_out_pc", out_pc, '0);
        chk("init_busy", busy, 1'b0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Basic stream from a start pulse.
        for (int i = 0; i < 7; i++) begin
            drv(tbl[i].st, 0, 0, 0, tbl[i].rdy);
            @(negedge clk);
            chk("tbl_mem_req", mem_req, tbl[i].req);
            if (tbl[i].req) chk("tbl_mem_address", mem_address, tbl[i].addr);
            chk("tbl_out_valid", out_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk("tbl_out_pc", out_pc, tbl[i].pc);
                chk("tbl_out_instruction", out_instruction, 32'h1000_0000 + tbl[i].pc);
            end
            chk("tbl_busy", busy, tbl[i].bsy);
            tick();
        end

        // Reset mid-stream, then backpressure with decode stalled.
        do_reset();
        drv(1, 0, 0, 0, 0); cyc();
        repeat (5) begin drv(0, 0, 0, 0, 0); cyc(); end
        @(negedge clk);
        chk("bp_full_req", mem_req, 1'b0);
        chk("bp_full_valid", out_valid, 1'b1);
        chk("bp_head_pc", out_pc, 3'd0);
        tick();
        repeat (8) begin drv(0, 0, 0, 0, 1); cyc(); end
        chk("bp_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) chk("bp_order", got[i], i);

        // Wrap-around over 10 deliveries.
        do_reset();
        drv(1, 0, 0, 0, 1); cyc();
        repeat (12) begin drv(0, 0, 0, 0, 1); cyc(); end
        chk("wrap_count", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) chk("wrap_pc", got[i], i % 8);

        // Redirect to 5 while pc 2 is buffered and pc 3 in flight.
        do_reset();
        drv(1, 0, 0, 0, 1); cyc();
        repeat (4) begin drv(0, 0, 0, 0, 1); cyc(); end
        drv(0, 0, 1, 5, 0); cyc();
        repeat (6) begin drv(0, 0, 0, 0, 1); cyc(); end
        begin
            int exp_r[6] = '{0, 1, 5, 6, 7, 0};
            chk("redir_count", got.size(), 6);
            for (int i = 0; i < got.size() && i < 6; i++) chk("redir_pc", got[i], exp_r[i]);
        end

        // Stop with one buffered and one in flight, decode stalled 3 cycles.
        do_reset();
        drv(1, 0, 0, 0, 1); cyc();
        repeat (4) begin drv(0, 0, 0, 0, 1); cyc(); end
        drv(0, 1, 0, 0, 0); cyc();
        repeat (2) begin drv(0, 0, 0, 0, 0); cyc(); end
        chk("drain_busy", busy, 1'b1);
        begin
            int k = 0;
            while (busy && k < 10) begin drv(0, 0, 0, 0, 1); cyc(); k++; end
        end
        chk("drain_idle", busy, 1'b0);
        chk("drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("drain_pc", got[i], i);
        repeat (3) begin drv(0, 0, 0, 0, 1); cyc(); end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 8; i++) imem[i] = $urandom;
        for (int n = 0; n < 800; n++) begin
            drv($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 7);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the synchronous instruction memory: generates fetch addresses, tracks the 1-cycle read latency, and hands instructions to decode over a valid/ready handshake.
- A 2-entry output buffer absorbs decode stalls without losing in-flight reads.
- Supports start, stop/drain and branch redirect with squash.
- Sits between the instruction memory (8 x 32-bit default) and the decode stage.

Parameters:
- ADDR_WIDTH, 3, width of the instruction memory address; PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after start.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- start  in  1  1-cycle pulse; begins fetching at RESET_PC; ignored unless IDLE.
- stop  in  1  1-cycle pulse; stops issuing and drains; ignored in IDLE.
- redirect_valid  in  1  branch/jump redirect; ignored in IDLE.
- redirect_addr  in  ADDR_WIDTH  new fetch address.
- mem_address  out  ADDR_WIDTH  address to instruction memory.
- mem_req  out  1  1 = mem_address is a real fetch this cycle.
- mem_instruction  in  DATA_WIDTH  memory data, valid one cycle after the mem_req cycle.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts; transfer = out_valid & out_ready.
- out_instruction  out  DATA_WIDTH  instruction at the buffer head.
- out_pc  out  ADDR_WIDTH  address of out_instruction.
- busy  out  1  1 in FETCH or DRAIN.

Behaviour:
- Reset values: mem_address=RESET_PC, mem_req=0, out_valid=0, out_instruction=0, out_pc=0, busy=0; FSM=IDLE, buffer empty, no read in flight, pc=RESET_PC.
- FSM states:
  - IDLE: waits for start, then goes to FETCH with pc=RESET_PC.
  - FETCH: issues reads.
  - DRAIN: no new issues; goes to IDLE when the buffer is empty and nothing is in flight.
- Issue rule (FETCH only): mem_req=1 when (buffer_count + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle. On issue, mem_address=pc and pc increments (wraps 2^ADDR_WIDTH-1 -> 0). mem_address holds its last value when mem_req=0.
- Response: the cycle after an issue, mem_instruction and its pc are written to the buffer tail unless squashed. The buffer never overflows; the issue rule guarantees this.
- Latency:
  - Empty buffer with out_ready=1: the issue in cycle N gives out_valid in cycle N+2 (registered output).
  - Sustained throughput: 1 instruction/cycle with out_ready held at 1.
- Handshake:
  - out_valid, out_instruction and out_pc stay stable until accepted.
  - The buffer preserves order, with no duplicates and no drops.
- Redirect (FETCH or DRAIN):
  - Flushes the buffer.
  - Squashes any in-flight read; its data is discarded the next cycle.
  - out_valid=0 the next cycle; pc=redirect_addr.
  - In FETCH, the next cycle issues redirect_addr.
  - A transfer in the redirect cycle itself is still a valid handoff.
- Stop: from FETCH goes to DRAIN; no issue in the stop cycle or afterwards; the in-flight read still lands in the buffer.
- Simultaneous redirect and stop: flush and squash apply and the state goes to DRAIN (now empty), so IDLE follows the next cycle.
- Simultaneous start and stop in IDLE: start wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight data is lost.

Test Plan:
- Basic stream (memory model returns 0x1000_0000+addr): start with out_ready=1.
  - Required: mem_address 0,1,2,... on consecutive cycles, first out_valid 2 cycles after the first issue.
  - Required: out_pc/out_instruction 0/0x10000000, 1/0x10000001, ... one per cycle.
- Backpressure: out_ready=0 for 5 cycles after start.
  - Required: exactly 2 buffered (pc 0,1); mem_req=0 while full.
  - Required: on release, pc 0,1,2,... delivered with no gap or duplicate.
- Wrap-around: run 10 fetches with ADDR_WIDTH=3.
  - Required: out_pc sequence 0..7,0,1 with matching instructions.
- Redirect: redirect_valid=1 with redirect_addr=5 while pc 3 is in flight and pc 2 is buffered.
  - Required: pc 2 and 3 are never presented; the next outputs are pc 5, 6.
- Stop/drain: stop with 1 buffered and 1 in flight, out_ready=0 for 3 cycles, then 1.
  - Required: busy=1 until both are delivered, then IDLE with busy=0 and no further mem_req.
- Async reset: assert reset=0 mid-stream between clock edges.
  - Required: out_valid=0, mem_req=0, busy=0 immediately; after release, start refetches from 0.
